// File: rtl/assoc_cache.sv
// assoc_cache: set-associative, write-back, write-allocate cache between a
// blocking single-word CPU port and a block-wide memory port.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cpu_valid/write/addr/wdata   CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready     read data and one-cycle completion pulse
//   mem_req/we/addr/wdata    block transaction to memory (we=1 write-back)
//   mem_rdata, mem_ack       fill block and one-cycle completion pulse
//   hit_count, miss_count    saturating event counters
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for a request; latches address/write/data
// S_LOOKUP    | parallel tag compare; hit completes, miss picks victim
// S_WRITEBACK | dirty victim block being written to memory
// S_ALLOCATE  | requested block being fetched into the victim way
module assoc_cache #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 256,
    parameter int WAYS   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_valid,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [32*WORDS-1:0] mem_wdata,
    input  logic [32*WORDS-1:0] mem_rdata,
    input  logic                mem_ack,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int BLK_W = 32 * WORDS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t state_q, state_d;

    // Word address only; the byte offset never affects behaviour.
    logic [LA_W-1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              refill_q, refill_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]  dirty_q, dirty_d;
    logic [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;

    // Tag and data arrays are plain storage without reset; valid bits guard them.
    logic [BLK_W-1:0] data_mem [SETS][WAYS];
    logic [TAG_W-1:0] tag_mem  [SETS][WAYS];

    logic              data_we;
    logic [WAY_W-1:0]  data_way;
    logic [BLK_W-1:0]  data_wblk;
    logic              tag_we;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_sel;
    logic [BLK_W-1:0]  hit_blk;
    logic              ack_ok;

    logic              unused_byte_off;
    assign unused_byte_off = ^cpu_addr[1:0];

    assign req_tag = addr_q[LA_W-1 -: TAG_W];
    assign req_idx = addr_q[OFF_W +: IDX_W];
    assign req_off = addr_q[0 +: OFF_W];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel = inv_found ? inv_way : ptr_q[req_idx];
    assign hit_blk    = data_mem[req_idx][hit_way];
    assign ack_ok     = mem_req_q && mem_ack;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        refill_d     = refill_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        ptr_d        = ptr_q;
        data_we      = 1'b0;
        data_way     = '0;
        data_wblk    = '0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // cpu_ready still high means the CPU has not yet seen completion.
                if (cpu_valid && !cpu_ready_q) begin
                    addr_d   = cpu_addr[ADDR_W-1:2];
                    write_d  = cpu_write;
                    wdata_d  = cpu_wdata;
                    refill_d = 1'b0;
                    state_d  = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    cpu_ready_d = 1'b1;
                    if (write_q) begin
                        data_we   = 1'b1;
                        data_way  = hit_way;
                        data_wblk = hit_blk;
                        data_wblk[{req_off, 5'd0} +: 32] = wdata_q;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end else begin
                        cpu_rdata_d = hit_blk[{req_off, 5'd0} +: 32];
                    end
                    // The lookup after a fill is the tail of a miss, not a hit.
                    if (!refill_q && (hit_count_q != '1)) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end
                    state_d = S_IDLE;
                end else begin
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                    victim_d  = victim_sel;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_mem[req_idx][victim_sel], req_idx, {(OFF_W+2){1'b0}}};
                        mem_wdata_d = data_mem[req_idx][victim_sel];
                        state_d     = S_WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                        state_d    = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                // mem_req stays up: the fill request follows back-to-back.
                if (ack_ok) begin
                    dirty_d[req_idx][victim_q] = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                    state_d    = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                if (ack_ok) begin
                    data_we   = 1'b1;
                    data_way  = victim_q;
                    data_wblk = mem_rdata;
                    tag_we    = 1'b1;
                    valid_d[req_idx][victim_q] = 1'b1;
                    dirty_d[req_idx][victim_q] = 1'b0;
                    if (WAYS > 1) begin
                        ptr_d[req_idx] = victim_q + 1'b1;
                    end else begin
                        ptr_d[req_idx] = '0;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    refill_d  = 1'b1;
                    state_d   = S_LOOKUP;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            victim_q     <= '0;
            refill_q     <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            refill_q     <= refill_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            ptr_q        <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[req_idx][data_way] <= data_wblk;
        end
        if (tag_we) begin
            tag_mem[req_idx][victim_q] <= req_tag;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;

    localparam int ADDR_W = 32;
    localparam int WORDS  = 4;
    localparam int SETS   = 256;
    localparam int WAYS   = 2;
    localparam int BLK_W  = 32 * WORDS;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_valid;
    logic              cpu_write;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_ack;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    assoc_cache #(
        .ADDR_W(ADDR_W),
        .WORDS (WORDS),
        .SETS  (SETS),
        .WAYS  (WAYS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_valid (cpu_valid),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Backing-store model: written on write-back acks, read on fill acks.
    logic [BLK_W-1:0] mem_model [logic [31:0]];

    function automatic logic [BLK_W-1:0] mem_fetch(input logic [31:0] a);
        logic [BLK_W-1:0] blk;
        if (mem_model.exists(a)) return mem_model[a];
        for (int k = 0; k < WORDS; k++) blk[32*k +: 32] = {a[15:0], 16'(k)};
        return blk;
    endfunction

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Results of the most recent access
    int               t_cycles, t_nwb, t_nfill, t_unstable;
    logic             t_timeout;
    logic [31:0]      t_rdata, t_wb_addr, t_fill_addr;
    logic [BLK_W-1:0] t_wb_data;

    // Called at a negedge; returns at the negedge where cpu_ready is seen.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int lat);
        int               cnt;
        bit               done;
        logic             s_we;
        logic [31:0]      s_addr;
        logic [BLK_W-1:0] s_wdata;
        t_cycles = 0; t_nwb = 0; t_nfill = 0; t_unstable = 0; t_timeout = 1'b0;
        t_rdata = '0; t_wb_addr = '0; t_fill_addr = '0; t_wb_data = '0;
        s_we = 1'b0; s_addr = '0; s_wdata = '0;
        cnt = 0; done = 0;
        cpu_valid = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        while (!done && t_cycles < 200) begin
            @(negedge clk);
            t_cycles++;
            if (t_cycles == 1) begin
                // Request already latched; these changes must be ignored.
                cpu_write = ~wr; cpu_addr = ~a; cpu_wdata = ~wd;
            end
            if (cpu_ready) begin
                t_rdata = cpu_rdata;
                done = 1;
                cpu_valid = 1'b0; cpu_write = 1'b0;
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            if (mem_req) begin
                if (cnt == 0) begin
                    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
                end else if (mem_we !== s_we || mem_addr !== s_addr || mem_wdata !== s_wdata) begin
                    t_unstable++;
                end
                if (cnt == lat) begin
                    if (mem_we) begin
                        t_nwb++;
                        t_wb_addr = mem_addr;
                        t_wb_data = mem_wdata;
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        t_nfill++;
                        t_fill_addr = mem_addr;
                        mem_rdata = mem_fetch(mem_addr);
                    end
                    mem_ack = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
        if (!done) t_timeout = 1'b1;
    endtask

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        int               lat;
        int               exp_cycles;
        int               exp_nwb;
        int               exp_nfill;
        logic [31:0]      exp_rdata;
        logic [31:0]      exp_wb_addr;
        logic [BLK_W-1:0] exp_wb_data;
        logic [31:0]      exp_fill_addr;
        int               exp_hits;
        int               exp_misses;
    } vec_t;

    vec_t vecs [12];

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_done"},   BLK_W'(t_timeout), '0);
        check({tag, "_cycles"}, BLK_W'(t_cycles), BLK_W'(v.exp_cycles));
        check({tag, "_nwb"},    BLK_W'(t_nwb), BLK_W'(v.exp_nwb));
        check({tag, "_nfill"},  BLK_W'(t_nfill), BLK_W'(v.exp_nfill));
        check({tag, "_stable"}, BLK_W'(t_unstable), '0);
        check({tag, "_hits"},   BLK_W'(hit_count), BLK_W'(v.exp_hits));
        check({tag, "_misses"}, BLK_W'(miss_count), BLK_W'(v.exp_misses));
        if (!v.wr) check({tag, "_rdata"}, BLK_W'(t_rdata), BLK_W'(v.exp_rdata));
        if (v.exp_nwb != 0) begin
            check({tag, "_wb_addr"}, BLK_W'(t_wb_addr), BLK_W'(v.exp_wb_addr));
            check({tag, "_wb_data"}, t_wb_data, v.exp_wb_data);
        end
        if (v.exp_nfill != 0) check({tag, "_fill_addr"}, BLK_W'(t_fill_addr), BLK_W'(v.exp_fill_addr));
        @(negedge clk);
        check({tag, "_ready_pulse"}, BLK_W'(cpu_ready), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        //            wr  addr          wdata         lat cyc wb fl rdata         wb_addr       wb_data                                   fill_addr     hit miss
        vecs[0]  = '{1'b0, 32'h0000_1234, 32'h0,        3,  7, 0, 1, 32'h1111_1111, 32'h0,        128'h0,                                   32'h0000_1230, 0, 1};
        vecs[1]  = '{1'b0, 32'h0000_1234, 32'h0,        3,  2, 0, 0, 32'h1111_1111, 32'h0,        128'h0,                                   32'h0,         1, 1};
        vecs[2]  = '{1'b1, 32'h0000_1238, 32'hDEAD_BEEF, 0, 2, 0, 0, 32'h0,         32'h0,        128'h0,                                   32'h0,         2, 1};
        vecs[3]  = '{1'b0, 32'h0000_1238, 32'h0,        0,  2, 0, 0, 32'hDEAD_BEEF, 32'h0,        128'h0,                                   32'h0,         3, 1};
        vecs[4]  = '{1'b0, 32'h0000_2230, 32'h0,        0,  4, 0, 1, 32'h2230_0000, 32'h0,        128'h0,                                   32'h0000_2230, 3, 2};
        vecs[5]  = '{1'b0, 32'h0000_3230, 32'h0,        2,  9, 1, 1, 32'h3230_0000, 32'h0000_1230, 128'h33333333_DEADBEEF_11111111_00000000, 32'h0000_3230, 3, 3};
        vecs[6]  = '{1'b0, 32'h0000_1238, 32'h0,        1,  5, 0, 1, 32'hDEAD_BEEF, 32'h0,        128'h0,                                   32'h0000_1230, 3, 4};
        vecs[7]  = '{1'b0, 32'h0000_3230, 32'h0,        0,  2, 0, 0, 32'h3230_0000, 32'h0,        128'h0,                                   32'h0,         4, 4};
        vecs[8]  = '{1'b1, 32'h0000_5000, 32'hA5A5_A5A5, 0, 4, 0, 1, 32'h0,         32'h0,        128'h0,                                   32'h0000_5000, 4, 5};
        vecs[9]  = '{1'b1, 32'h0000_6004, 32'h5A5A_5A5A, 0, 4, 0, 1, 32'h0,         32'h0,        128'h0,                                   32'h0000_6000, 4, 6};
        vecs[10] = '{1'b0, 32'h0000_5000, 32'h0,        0,  2, 0, 0, 32'hA5A5_A5A5, 32'h0,        128'h0,                                   32'h0,         5, 6};
        vecs[11] = '{1'b0, 32'h0000_4568, 32'h0,        10, 14, 0, 1, 32'h4560_0002, 32'h0,       128'h0,                                   32'h0000_4560, 5, 7};

        mem_model[32'h0000_1230] = 128'h33333333_22222222_11111111_00000000;

        reset_n = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_ready",  BLK_W'(cpu_ready), '0);
        check("rst_cpu_rdata",  BLK_W'(cpu_rdata), '0);
        check("rst_mem_req",    BLK_W'(mem_req), '0);
        check("rst_mem_we",     BLK_W'(mem_we), '0);
        check("rst_mem_addr",   BLK_W'(mem_addr), '0);
        check("rst_mem_wdata",  mem_wdata, '0);
        check("rst_hit_count",  BLK_W'(hit_count), '0);
        check("rst_miss_count", BLK_W'(miss_count), '0);

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            do_access(v.wr, v.addr, v.wdata, v.lat);
            check_result($sformatf("row%0d", i), v);
        end

        // mem_ack without an outstanding request must do nothing.
        mem_ack = 1'b1; mem_rdata = '1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_ack_req",    BLK_W'(mem_req), '0);
            check("stray_ack_ready",  BLK_W'(cpu_ready), '0);
            check("stray_ack_misses", BLK_W'(miss_count), BLK_W'(7));
            @(negedge clk);
        end
        v = '{1'b0, 32'h0000_4568, 32'h0, 0, 2, 0, 0, 32'h4560_0002, 32'h0, 128'h0, 32'h0, 6, 7};
        do_access(v.wr, v.addr, v.wdata, v.lat);
        check_result("stray_ack_hit", v);

        // Dirty victim in set 0 forces a write-back; reset in the middle of it.
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_7000; cpu_wdata = '0;
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_wb_seen",  BLK_W'(mem_req), BLK_W'(1));
        check("rst_wb_we",    BLK_W'(mem_we), BLK_W'(1));
        check("rst_wb_addr",  BLK_W'(mem_addr), BLK_W'(32'h0000_5000));
        check("rst_wb_word0", BLK_W'(mem_wdata[31:0]), BLK_W'(32'hA5A5_A5A5));
        #2;
        reset_n = 1'b0;
        cpu_valid = 1'b0;
        #1;
        check("midrst_mem_req",    BLK_W'(mem_req), '0);
        check("midrst_mem_we",     BLK_W'(mem_we), '0);
        check("midrst_hit_count",  BLK_W'(hit_count), '0);
        check("midrst_miss_count", BLK_W'(miss_count), '0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        v = '{1'b0, 32'h0000_3230, 32'h0, 1, 5, 0, 1, 32'h3230_0000, 32'h0, 128'h0, 32'h0000_3230, 0, 1};
        do_access(v.wr, v.addr, v.wdata, v.lat);
        check_result("post_rst_3230", v);
        // The dirty 0x5000 line was never written back, so memory still has the old block.
        v = '{1'b0, 32'h0000_5000, 32'h0, 0, 4, 0, 1, 32'h5000_0000, 32'h0, 128'h0, 32'h0000_5000, 0, 2};
        do_access(v.wr, v.addr, v.wdata, v.lat);
        check_result("post_rst_5000", v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
